// File: rtl/fifo_uart_drain_ctrl_pkg.sv
// fifo_uart_drain_ctrl_pkg: shared widths, FSM states and burst-length helper for the FIFO->UART drain controller.
package fifo_uart_drain_ctrl_pkg;
    localparam int DATA_W = 8;
    localparam int COUNT_W = 13;
    typedef enum logic [2:0] {IDLE, SYNC, LEN, RD, LATCH, SEND} state_e;
    // A non-empty FIFO whose count still reads 0 (count lag) drains one byte.
    function automatic logic [7:0] burst_len(input logic [COUNT_W-1:0] count, input int max_burst);
        int c = int'(count);
        return c == 0 ? 8'd1 : c > max_burst ? 8'(max_burst) : 8'(c);
    endfunction
endpackage

// File: rtl/fifo_uart_drain_ctrl_if.sv
// fifo_uart_drain_ctrl_if: FIFO read port and UART valid/ready byte port of the drain controller.
interface fifo_uart_drain_ctrl_if;
    import fifo_uart_drain_ctrl_pkg::*;
    logic [DATA_W-1:0] fifo_dout;
    logic fifo_empty;
    logic [COUNT_W-1:0] fifo_rd_data_count;
    logic fifo_rd_en;
    logic [DATA_W-1:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    modport master (
        input fifo_dout, fifo_empty, fifo_rd_data_count, tx_ready,
        output fifo_rd_en, tx_data, tx_valid
    );
    modport slave (
        output fifo_dout, fifo_empty, fifo_rd_data_count, tx_ready,
        input fifo_rd_en, tx_data, tx_valid
    );
endinterface

// File: rtl/fifo_uart_drain_ctrl_idle_timer.sv
// fifo_uart_drain_ctrl_idle_timer: saturating idle counter, expired once it holds TIMEOUT_CYC.
module fifo_uart_drain_ctrl_idle_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d = clear ? '0 : (inc && cnt_q != W'(TIMEOUT_CYC)) ? cnt_q + 1'b1 : cnt_q;
    assign expired = cnt_q == W'(TIMEOUT_CYC);
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/fifo_uart_drain_ctrl.sv
// fifo_uart_drain_ctrl: drains the RX FIFO to the UART in framed bursts (sync byte, length, payload).
module fifo_uart_drain_ctrl
    import fifo_uart_drain_ctrl_pkg::*;
#(
    parameter int THRESH = 64,
    parameter int MAX_BURST = 255,
    parameter int TIMEOUT_CYC = 100000,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic uart_tx_clk,
    input  logic reset,
    input  logic enable,
    fifo_uart_drain_ctrl_if.master bus,
    output logic busy,
    output logic [31:0] bytes_sent,
    output logic underrun
);
    state_e state_q, state_d;
    logic [7:0] len_q, len_d, rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [31:0] sent_q, sent_d;
    logic underrun_q, underrun_d, busy_q, expired, start, hs, take;
    assign hs = bus.tx_valid && bus.tx_ready;
    assign take = state_q == SEND && hs;
    assign start = enable && !bus.fifo_empty
                 && (int'(bus.fifo_rd_data_count) >= THRESH || expired);
    fifo_uart_drain_ctrl_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk(uart_tx_clk),
        .rst(reset),
        .clear(state_q != IDLE || bus.fifo_empty || start),
        .inc(!bus.fifo_empty),
        .expired(expired)
    );
    always_ff @(posedge uart_tx_clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q <= '0;
            rem_q <= '0;
            data_q <= '0;
            sent_q <= '0;
            underrun_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            rem_q <= rem_d;
            data_q <= data_d;
            sent_q <= sent_d;
            underrun_q <= underrun_d;
            busy_q <= state_d != IDLE;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SYNC : IDLE;
            SYNC:    state_d = hs ? LEN : SYNC;
            LEN:     state_d = hs ? RD : LEN;
            RD:      state_d = bus.fifo_empty ? IDLE : LATCH;
            LATCH:   state_d = SEND;
            SEND:    state_d = hs ? (rem_q == 8'd1 ? IDLE : RD) : SEND;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        len_d = (state_q == IDLE && start) ? burst_len(bus.fifo_rd_data_count, MAX_BURST) : len_q;
        rem_d = (state_q == IDLE && start) ? len_d : take ? rem_q - 8'd1 : rem_q;
        data_d = state_q == LATCH ? bus.fifo_dout : data_q;
        sent_d = take ? sent_q + 32'd1 : sent_q;
        underrun_d = underrun_q || (state_q == RD && bus.fifo_empty);
    end
    assign bus.fifo_rd_en = state_q == RD && !bus.fifo_empty;
    assign bus.tx_valid = state_q == SYNC || state_q == LEN || state_q == SEND;
    assign bus.tx_data = state_q == SYNC ? SYNC_BYTE : state_q == LEN ? len_q : data_q;
    assign busy = busy_q;
    assign bytes_sent = sent_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_fifo_uart_drain_ctrl.sv
// tb_fifo_uart_drain_ctrl: random-stall bench with a queue FIFO and a frame-level reference of the expected UART stream.
module tb_fifo_uart_drain_ctrl;
    import fifo_uart_drain_ctrl_pkg::*;
    localparam int THRESH = 16;
    localparam int MAXB = 20;
    localparam int TMO = 40;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, busy, underrun;
    logic [31:0] bytes_sent;
    fifo_uart_drain_ctrl_if bus ();
    fifo_uart_drain_ctrl #(
        .THRESH(THRESH), .MAX_BURST(MAXB), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)
    ) dut (
        .uart_tx_clk(clk), .reset(rst), .enable(enable), .bus(bus),
        .busy(busy), .bytes_sent(bytes_sent), .underrun(underrun)
    );
    always #5 clk = ~clk;
    logic [7:0] fifo_q[$], exp_q[$];
    bit pl_q[$];
    int vectors = 0, miscompares = 0, low_pct = 0, rd_pulses = 0, pl_seen = 0, gap = 0;
    bit force_empty = 0, gap_valid = 0, prev_valid = 0, prev_ready = 0, prev_rd = 0, prev_busy = 0, prev_rst = 1;
    logic [7:0] prev_data = '0;
    logic [31:0] model_sent = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic void drive_fifo();
        bus.fifo_empty = force_empty || fifo_q.size() == 0;
        bus.fifo_rd_data_count = force_empty ? '0 : COUNT_W'(fifo_q.size());
    endfunction
    // Expected stream: the whole FIFO content split into frames of at most MAXB bytes.
    function automatic void plan();
        int i = 0;
        while (i < fifo_q.size()) begin
            int n;
            n = (fifo_q.size() - i) > MAXB ? MAXB : fifo_q.size() - i;
            exp_q.push_back(8'hA5); pl_q.push_back(0);
            exp_q.push_back(8'(n)); pl_q.push_back(0);
            for (int k = 0; k < n; k++) begin
                exp_q.push_back(fifo_q[i + k]); pl_q.push_back(1);
            end
            i += n;
        end
    endfunction
    task automatic step();
        bit pop;
        @(negedge clk);
        if (bus.fifo_rd_en) begin
            check("rd_en_while_empty", 32'(bus.fifo_empty), 0);
            check("rd_en_back_to_back", 32'(prev_rd), 0);
            rd_pulses++;
        end
        if (prev_valid && !prev_ready && !prev_rst) begin
            check("valid_hold", 32'(bus.tx_valid), 1);
            check("data_hold", 32'(bus.tx_data), 32'(prev_data));
        end
        if (bus.tx_valid && bus.tx_ready && !rst) begin
            if (exp_q.size() == 0) check("extra_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
            else begin
                check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                if (pl_q.pop_front()) begin
                    model_sent++;
                    pl_seen++;
                end
            end
        end
        if (busy && !prev_busy && gap_valid && fifo_q.size() < THRESH) check("idle_gap", gap, TMO + 1);
        if (busy || bus.fifo_empty) begin
            gap = 0;
            gap_valid = enable;
        end else gap++;
        if (!enable || rst) gap_valid = 0;
        prev_valid = bus.tx_valid; prev_ready = bus.tx_ready; prev_data = bus.tx_data;
        prev_rd = bus.fifo_rd_en; prev_busy = busy; prev_rst = rst;
        pop = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
        bus.tx_ready = $urandom_range(99) >= low_pct;
        drive_fifo();
    endtask
    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) check({tag, "_drain_timeout"}, exp_q.size(), 0);
    endtask
    task automatic load(input int n, input bit ramp, input logic [7:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(ramp ? base + 8'(i) : 8'($urandom));
        drive_fifo();
    endtask
    task automatic wait_payload(input int n);
        int c = 0;
        pl_seen = 0;
        while (pl_seen < n && c < 2000) begin
            step();
            c++;
        end
        if (c >= 2000) check("payload_wait_timeout", pl_seen, n);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
        check({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_bytes_sent"}, bytes_sent, 0);
        check({tag, "_underrun"}, 32'(underrun), 0);
    endtask
    initial begin
        bus.tx_ready = 1'b1;
        bus.fifo_dout = '0;
        drive_fifo();
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        enable = 1'b1;
        // Threshold burst with a ramp payload
        load(THRESH, 1, 8'h00);
        plan();
        rd_pulses = 0;
        wait_done("thresh");
        check("thresh_rd_pulses", rd_pulses, THRESH);
        check("thresh_bytes_sent", bytes_sent, THRESH);
        check("thresh_busy_after", 32'(busy), 0);
        // Long backlog: two full frames then a timeout-forced short frame
        load(2 * MAXB + 10, 0, 8'h00);
        plan();
        wait_done("backlog");
        check("backlog_bytes_sent", bytes_sent, model_sent);
        // Few bytes below threshold drain only after the idle timeout
        load(5, 1, 8'h40);
        plan();
        wait_done("timeout");
        // Disabled controller holds off, then drains once enabled
        enable = 1'b0;
        load(5, 1, 8'h50);
        plan();
        repeat (TMO + 20) step();
        check("disabled_nothing_sent", exp_q.size(), 7);
        check("disabled_busy", 32'(busy), 0);
        enable = 1'b1;
        wait_done("enable");
        // Random ready stalls
        low_pct = 30;
        for (int r = 0; r < 4; r++) begin
            load($urandom_range(45, 1), 0, 8'h00);
            plan();
            wait_done("stall");
        end
        low_pct = 0;
        check("stall_bytes_sent", bytes_sent, model_sent);
        check("no_underrun_yet", 32'(underrun), 0);
        // FIFO runs dry mid-frame
        load(10, 1, 8'h60);
        plan();
        wait_payload(3);
        force_empty = 1;
        drive_fifo();
        repeat (3) step();
        check("underrun_set", 32'(underrun), 1);
        check("underrun_idle", 32'(busy), 0);
        exp_q.delete();
        pl_q.delete();
        force_empty = 0;
        drive_fifo();
        plan();
        wait_done("after_underrun");
        check("underrun_sticky", 32'(underrun), 1);
        check("underrun_bytes_sent", bytes_sent, model_sent);
        // Reset while a payload byte waits for ready
        load(20, 1, 8'h80);
        plan();
        wait_payload(2);
        low_pct = 100;
        bus.tx_ready = 1'b0;
        for (int c = 0; c < 10 && !bus.tx_valid; c++) step();
        check("send_reached", 32'(bus.tx_valid), 1);
        rst = 1'b1;
        step();
        check_zero("midsend_reset");
        rst = 1'b0;
        low_pct = 0;
        exp_q.delete();
        pl_q.delete();
        model_sent = 0;
        plan();
        wait_done("restart");
        check("restart_bytes_sent", bytes_sent, model_sent);
        check("restart_bytes_total", bytes_sent, 17);
        check("restart_fifo_drained", fifo_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
